// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - load/store responder: byte-lane RAM plus MMIO page
// (UART TX FIFO, status register, free-running cycle counter).
module dmem_io_responder #(
  parameter int RAM_WORDS_LOG2 = 14,
  parameter int TX_DEPTH_LOG2  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] r_addr,
  input  logic [16:0] w_addr,
  input  logic [3:0]  we,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_DEPTH = 1 << RAM_WORDS_LOG2;
  localparam int DEPTH     = 1 << TX_DEPTH_LOG2;
  localparam int PW        = TX_DEPTH_LOG2;
  localparam int CW        = TX_DEPTH_LOG2 + 1;

  logic [RAM_WORDS_LOG2-1:0] r_idx, w_idx;
  logic [3:0]                ram_we;
  logic [31:0]               ram_rd;

  logic [31:0]   r_data_q, r_data_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_q [DEPTH];

  logic        full, empty, push, pop, push_ok, ovf_clr;
  logic [31:0] status;
  logic        unused_bits;

  assign r_idx  = r_addr[RAM_WORDS_LOG2+1:2];
  assign w_idx  = w_addr[RAM_WORDS_LOG2+1:2];
  assign ram_we = we & {4{~w_addr[16]}};
  assign unused_bits = ^{r_addr, w_addr, w_data};

  // Each bank bypasses its own lane so a same-word read sees the new byte (write-first).
  for (genvar i = 0; i < 4; i++) begin : g_bank
    logic [7:0] mem [RAM_DEPTH];
    always_ff @(posedge clk) begin
      if (ram_we[i]) mem[w_idx] <= w_data[8*i +: 8];
    end
    assign ram_rd[8*i +: 8] = (ram_we[i] && (w_idx == r_idx)) ? w_data[8*i +: 8] : mem[r_idx];
  end

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = we[0] && w_addr[16] && (w_addr[3:2] == 2'd0);
  assign ovf_clr = we[0] && w_addr[16] && (w_addr[3:2] == 2'd1) && w_data[2];
  assign pop     = !empty && tx_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[tail_q] <= w_data[7:0];
  end

  always_comb begin
    status           = '0;
    status[0]        = full;
    status[1]        = empty;
    status[2]        = ovf_q;
    status[8 +: CW]  = count_q;

    r_data_d = 32'd0;
    if (!r_addr[16]) begin
      r_data_d = ram_rd;
    end else begin
      case (r_addr[3:2])
        2'd1:    r_data_d = status;
        2'd2:    r_data_d = cycle_q;
        default: r_data_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    cycle_d = cycle_q + 32'd1;

    if (pop)     head_d = head_q + PW'(1);
    if (push_ok) tail_d = tail_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    // A drop in the same cycle as a clear leaves the flag set.
    if (ovf_clr)                ovf_d = 1'b0;
    if (push && full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= 32'd0;
      cycle_q  <= 32'd0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      r_data_q <= r_data_d;
      cycle_q  <= cycle_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign r_data   = r_data_q;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[head_q];

endmodule

// File: tb/tb_dmem_io_responder.sv
// tb/tb_dmem_io_responder.sv - directed and random checks of dmem_io_responder against a queue/array model.
module tb_dmem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] r_addr, w_addr;
  logic [3:0]  we;
  logic [31:0] w_data, r_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] mram [64];
  logic [7:0]  mq [$];
  bit          movf;
  logic [31:0] mcyc;

  logic [31:0] c1, c2;
  logic [7:0]  last;

  dmem_io_responder dut (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .w_addr(w_addr), .we(we),
    .w_data(w_data), .r_data(r_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    v = 32'd0;
    if (!r_addr[16]) begin
      v = mram[r_addr[7:2]];
      if (!w_addr[16] && (w_addr[7:2] == r_addr[7:2]))
        for (int i = 0; i < 4; i++) if (we[i]) v[8*i +: 8] = w_data[8*i +: 8];
    end else if (r_addr[3:2] == 2'd1) begin
      v = (32'(mq.size()) << 8) + (movf ? 32'd4 : 32'd0)
        + ((mq.size() == 0) ? 32'd2 : 32'd0) + ((mq.size() == 4) ? 32'd1 : 32'd0);
    end else if (r_addr[3:2] == 2'd2) begin
      v = mcyc;
    end
    return v;
  endfunction

  task automatic model_update();
    bit push, pop, clr;
    push = we[0] && w_addr[16] && (w_addr[3:2] == 2'd0);
    clr  = we[0] && w_addr[16] && (w_addr[3:2] == 2'd1) && w_data[2];
    pop  = (mq.size() != 0) && tx_ready;
    if (!w_addr[16])
      for (int i = 0; i < 4; i++) if (we[i]) mram[w_addr[7:2]][8*i +: 8] = w_data[8*i +: 8];
    if (clr) movf = 1'b0;
    if (pop) mq.delete(0);
    if (push) begin
      if (mq.size() < 4) mq.push_back(w_data[7:0]);
      else movf = 1'b1;
    end
    mcyc = mcyc + 32'd1;
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    mcyc = 32'd0;
  endtask

  task automatic tick();
    logic [31:0] er;
    er = model_read();
    model_update();
    @(posedge clk);
    #1;
    check("r_data", r_data, er);
    check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
    check("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
  endtask

  task automatic idle();
    we = 4'h0; w_addr = 17'h0; w_data = 32'h0; r_addr = 17'h1000C;
  endtask

  task automatic push_byte(input logic [7:0] b);
    we = 4'h1; w_addr = 17'h10000; w_data = {24'h0, b};
    tick();
  endtask

  initial begin
    idle();
    tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_r_data", r_data, 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      we = 4'hF; w_addr = 17'(i << 2); w_data = $urandom;
      tick();
    end

    we = 4'hF; w_addr = 17'h00010; w_data = 32'h0; tick();
    we = 4'h1; w_data = 32'h000000AA; tick();
    we = 4'h4; w_data = 32'h00CC0000; tick();
    idle(); r_addr = 17'h00010; tick();
    check("byte_store", r_data, 32'h00CC00AA);

    we = 4'hF; w_addr = 17'h00020; w_data = 32'h11223344; r_addr = 17'h1000C; tick();
    we = 4'hC; w_data = 32'hBEEF0000; r_addr = 17'h00020; tick();
    check("write_first", r_data, 32'hBEEF3344);

    for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i));
    idle(); r_addr = 17'h10004; tick();
    check("status_overflow", r_data, 32'h00000405);
    check("head_after_fill", 32'(tx_data), 32'h41);
    we = 4'h1; w_addr = 17'h10004; w_data = 32'h4; r_addr = 17'h10004; tick();
    idle(); r_addr = 17'h10004; tick();
    check("status_cleared", r_data, 32'h00000401);

    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(tx_data), 32'(8'h41 + i));
      tick();
    end
    check("drain_valid_low", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0; r_addr = 17'h10004; tick();
    check("status_empty", r_data, 32'h00000002);

    for (int i = 0; i < 4; i++) push_byte(8'(8'h61 + i));
    tx_ready = 1'b1; push_byte(8'h55);
    tx_ready = 1'b0; idle(); r_addr = 17'h10004; tick();
    check("full_push_pop_status", r_data, 32'h00000401);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      last = tx_data;
      tick();
    end
    check("push_pop_last", 32'(last), 32'h55);
    tx_ready = 1'b0;

    r_addr = 17'h10008; tick();
    c1 = r_data;
    r_addr = 17'h1000C;
    repeat (9) tick();
    r_addr = 17'h10008; tick();
    c2 = r_data;
    check("cycle_delta", c2 - c1, 32'd10);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom;
      we = (r[1:0] == 2'd0) ? 4'h0 : 4'($urandom);
      w_addr = r[2] ? {1'b1, 12'($urandom), 2'($urandom), 2'b00}
                    : {1'b0, 8'h00, 6'($urandom), 2'($urandom)};
      w_data = $urandom;
      r_addr = r[4] ? {1'b1, 12'($urandom), 2'($urandom), 2'($urandom)}
                    : {1'b0, 8'h00, 6'($urandom), 2'($urandom)};
      tx_ready = r[3] & r[5];
      tick();
    end

    idle(); tx_ready = 1'b0; tick();
    tx_ready = 1'b1; tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h71 + i));
    idle(); tx_ready = 1'b1; r_addr = 17'h10008; tick();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_r_data", r_data, 32'd0);
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tx_ready = 1'b0; r_addr = 17'h10008; tick();
    check("cycle_after_reset", r_data, 32'd0);
    r_addr = 17'h10004; tick();
    check("status_after_reset", r_data, 32'h00000002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
